// File: rtl/qsys_debug_pkg.sv
// qsys_debug_pkg: shared FSM states and jdo field map for the OCI debug memory controller.
package qsys_debug_pkg;
   localparam int JDO_W        = 38;
   localparam int JDO_ADDR_MSB = 25;
   localparam int JDO_ADDR_LSB = 17;
   localparam int JDO_RD_BIT   = 35;
   localparam int JDO_WD_MSB   = 34;
   localparam int JDO_WD_LSB   = 3;
   typedef enum logic [2:0] {IDLE, J_RD, J_WR, J_DONE, C_RD} state_t;
endpackage

// File: rtl/qsys_debug_ocimem_ram.sv
// qsys_debug_ocimem_ram: single-port DEPTHx32 RAM, synchronous read with one cycle latency.
module qsys_debug_ocimem_ram #(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   output logic [31:0]   o_rdata
);
   logic [31:0] r_mem [DEPTH];
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_addr] <= i_wdata;
      o_rdata <= r_mem[i_addr];
   end
endmodule

// File: rtl/qsys_debug_ocimem_ctrl.sv
// qsys_debug_ocimem_ctrl: JTAG/CPU arbitrated debug RAM controller; JTAG has priority.
// Define QSYS_DEBUG_OCIMEM_AUTOINC_EN to post-increment jaddr after each in-range JTAG access.
module qsys_debug_ocimem_ctrl
   import qsys_debug_pkg::*;
#(
   parameter int DEPTH = 256,
   parameter int AW    = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [JDO_W-1:0] jdo,
   input  logic             take_action_ocimem_a,
   input  logic             take_no_action_ocimem_a,
   input  logic             take_action_ocimem_b,
   output logic [31:0]      MonDReg,
   output logic             monitor_ready,
   output logic             monitor_error,
   input  logic [AW-1:0]    avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_waitrequest
);
   state_t      r_state, w_next;
   logic [8:0]  r_jaddr;
   logic        r_pend, r_pend_wr, r_ready, r_error;
   logic [31:0] r_wdata, r_mon, r_readdata, w_q, w_ram_wdata;
   logic [AW-1:0] w_ram_addr;
   logic        w_strobe, w_drop, w_newreq, w_jreq, w_jwr, w_inr, w_cwr, w_we, w_jstate;
   logic        w_unused_jdo;

   assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_RD_BIT+1], jdo[JDO_WD_LSB-1:0]};
   assign w_strobe = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
   assign w_drop   = w_strobe & r_pend;
   assign w_newreq = ~r_pend & ((take_action_ocimem_a & jdo[JDO_RD_BIT]) | take_no_action_ocimem_a
                                | take_action_ocimem_b);
   // A fresh strobe is served straight from IDLE so the access starts on the next cycle.
   assign w_jreq   = r_pend | w_newreq;
   assign w_jwr    = r_pend ? r_pend_wr : take_action_ocimem_b;
   assign w_inr    = 32'(r_jaddr) < DEPTH;
   assign w_cwr    = (r_state == IDLE) & ~w_jreq & ~avs_read & avs_write;
   assign w_jstate = r_state inside {J_RD, J_WR, J_DONE};
   assign w_we     = ((r_state == J_WR) & w_inr) | w_cwr;
   assign w_ram_addr  = w_jstate ? r_jaddr[AW-1:0] : avs_address;
   assign w_ram_wdata = (r_state == J_WR) ? r_wdata : avs_writedata;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:        w_next = w_jreq ? (w_jwr ? J_WR : J_RD) : (avs_read ? C_RD : IDLE);
         J_RD, J_WR:  w_next = J_DONE;
         J_DONE:      w_next = IDLE;
         C_RD:        w_next = IDLE;
         default:     w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= IDLE;
         r_jaddr    <= '0;
         r_pend     <= 1'b0;
         r_pend_wr  <= 1'b0;
         r_wdata    <= '0;
         r_ready    <= 1'b0;
         r_error    <= 1'b0;
         r_mon      <= '0;
         r_readdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_drop) r_error <= 1'b1;
         else if (take_action_ocimem_a) begin
            r_ready <= 1'b0;
            r_error <= 1'b0;
            r_jaddr <= jdo[JDO_ADDR_MSB:JDO_ADDR_LSB];
         end
         if (w_newreq) begin
            r_pend    <= 1'b1;
            r_pend_wr <= take_action_ocimem_b;
            r_wdata   <= jdo[JDO_WD_MSB:JDO_WD_LSB];
         end
         if (r_state == J_DONE) begin
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
            if (!w_inr) r_error <= 1'b1;
            else begin
               if (!r_pend_wr) r_mon <= w_q;
`ifdef QSYS_DEBUG_OCIMEM_AUTOINC_EN
               r_jaddr <= r_jaddr + 9'd1;
`else
               r_jaddr <= r_jaddr;
`endif
            end
         end
         if (r_state == C_RD) r_readdata <= w_q;
      end
   end

   qsys_debug_ocimem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .clk     (clk),
      .i_we    (w_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_q)
   );

   assign MonDReg         = r_mon;
   assign monitor_ready   = r_ready;
   assign monitor_error   = r_error;
   assign avs_readdata    = r_readdata;
   assign avs_waitrequest = (avs_read | avs_write) & ~((r_state == C_RD) | w_cwr);
endmodule

// File: tb/tb_qsys_debug_ocimem_ctrl.sv
// tb_qsys_debug_ocimem_ctrl: scoreboard bench; expectations queued at stimulus, checked by a monitor.
module tb_qsys_debug_ocimem_ctrl;
`ifdef QSYS_DEBUG_OCIMEM_AUTOINC_EN
   localparam int DEPTH = 512;
   localparam int AW    = 9;
`else
   localparam int DEPTH = 256;
   localparam int AW    = 8;
`endif
   logic          clk = 1'b0;
   logic          reset_n = 1'b1;
   logic [37:0]   jdo = '0;
   logic          ta_a = 1'b0, tna_a = 1'b0, ta_b = 1'b0;
   logic [31:0]   MonDReg;
   logic          monitor_ready, monitor_error;
   logic [AW-1:0] avs_address = '0;
   logic          avs_read = 1'b0, avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [31:0]   avs_readdata;
   logic          avs_waitrequest;

   int n_tests = 0;
   int n_fail = 0;
   logic [32:0] q_j[$];
   logic [31:0] q_cpu[$];

   qsys_debug_ocimem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk                     (clk),
      .reset_n                 (reset_n),
      .jdo                     (jdo),
      .take_action_ocimem_a    (ta_a),
      .take_no_action_ocimem_a (tna_a),
      .take_action_ocimem_b    (ta_b),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .avs_address             (avs_address),
      .avs_read                (avs_read),
      .avs_write               (avs_write),
      .avs_writedata           (avs_writedata),
      .avs_readdata            (avs_readdata),
      .avs_waitrequest         (avs_waitrequest)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // monitor: a rising monitor_ready is a finished JTAG access; a granted CPU read yields data one edge later
   initial begin
      logic prev_rdy = 1'b0;
      logic cpu_due = 1'b0;
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (cpu_due) begin
            if (q_cpu.size() == 0) chk("cpu_unexpected", avs_readdata, 32'hxxxx_xxxx);
            else chk("cpu_readdata", avs_readdata, q_cpu.pop_front());
            cpu_due = 1'b0;
         end
         if (reset_n && avs_read && !avs_waitrequest) cpu_due = 1'b1;
         if (monitor_ready && !prev_rdy) begin
            if (q_j.size() == 0) chk("jtag_unexpected", {31'd0, monitor_ready}, 32'd0);
            else begin
               e = q_j.pop_front();
               chk("jtag_mondreg", MonDReg, e[31:0]);
               chk("jtag_error", {31'd0, monitor_error}, {31'd0, e[32]});
            end
         end
         prev_rdy = monitor_ready;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic load_a(input logic [8:0] a, input logic rd);
      jdo = '0;
      jdo[25:17] = a;
      jdo[35] = rd;
      ta_a = 1'b1;
      cyc(1);
      ta_a = 1'b0;
   endtask

   task automatic read_na();
      tna_a = 1'b1;
      cyc(1);
      tna_a = 1'b0;
   endtask

   task automatic write_b(input logic [31:0] d);
      jdo = '0;
      jdo[34:3] = d;
      ta_b = 1'b1;
      cyc(1);
      ta_b = 1'b0;
   endtask

   task automatic cpu_write(input int a, input logic [31:0] d);
      avs_address = AW'(a);
      avs_writedata = d;
      avs_write = 1'b1;
      @(negedge clk);
      chk("cpu_write_nowait", {31'd0, avs_waitrequest}, 32'd0);
      cyc(1);
      avs_write = 1'b0;
   endtask

   task automatic cpu_read(input int a, input logic [31:0] exp);
      int n = 0;
      q_cpu.push_back(exp);
      avs_address = AW'(a);
      avs_read = 1'b1;
      repeat (20) begin
         @(negedge clk);
         if (!avs_waitrequest) break;
         n++;
      end
      chk("cpu_read_waits", n, 1);
      cyc(1);
      avs_read = 1'b0;
      cyc(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      #1 reset_n = 1'b0;
      @(negedge clk);
      chk("rst_mondreg", MonDReg, 32'd0);
      chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
      chk("rst_error", {31'd0, monitor_error}, 32'd0);
      chk("rst_readdata", avs_readdata, 32'd0);
      chk("rst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
      cyc(2);
      reset_n = 1'b1;
      cyc(1);

      // JTAG write then read-after-load of the same word
      load_a(9'd5, 1'b0);
      @(negedge clk);
      chk("load_clears_ready", {31'd0, monitor_ready}, 32'd0);
      q_j.push_back({1'b0, 32'd0});
      write_b(32'hDEAD_BEEF);
      cyc(3);
      q_j.push_back({1'b0, 32'hDEAD_BEEF});
      load_a(9'd5, 1'b1);
      @(negedge clk);
      chk("lat_jrd_ready", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      chk("lat_jdone_ready", {31'd0, monitor_ready}, 32'd0);
      @(negedge clk);
      chk("lat2_ready", {31'd0, monitor_ready}, 32'd1);
      chk("lat2_mondreg", MonDReg, 32'hDEAD_BEEF);
      cyc(1);

      cpu_read(5, 32'hDEAD_BEEF);
      cpu_write(44, 32'h1234_5678);
      cpu_read(44, 32'h1234_5678);

`ifdef QSYS_DEBUG_OCIMEM_AUTOINC_EN
      load_a(9'd10, 1'b0);
      q_j.push_back({1'b0, 32'hDEAD_BEEF});
      write_b(32'd1);
      cyc(3);
      write_b(32'd2);
      cyc(3);
      write_b(32'd3);
      cyc(3);
      cpu_read(10, 32'd1);
      cpu_read(11, 32'd2);
      cpu_read(12, 32'd3);
      load_a(9'd511, 1'b0);
      q_j.push_back({1'b0, 32'hDEAD_BEEF});
      write_b(32'h0000_00A5);
      cyc(3);
      write_b(32'h0000_005A);
      cyc(3);
      cpu_read(511, 32'h0000_00A5);
      cpu_read(0, 32'h0000_005A);
`else
      // out-of-range address: flags set, RAM alias (300 mod 256 = 44) untouched
      q_j.push_back({1'b1, 32'hDEAD_BEEF});
      load_a(9'd300, 1'b1);
      cyc(3);
      write_b(32'hFFFF_FFFF);
      cyc(3);
      chk("oor_error", {31'd0, monitor_error}, 32'd1);
      chk("oor_ready", {31'd0, monitor_ready}, 32'd1);
      cpu_read(44, 32'h1234_5678);
      load_a(9'd44, 1'b0);
      @(negedge clk);
      chk("clear_error", {31'd0, monitor_error}, 32'd0);
      chk("clear_ready", {31'd0, monitor_ready}, 32'd0);
      cyc(1);
      // without auto-increment both writes land at address 10
      load_a(9'd10, 1'b0);
      q_j.push_back({1'b0, 32'hDEAD_BEEF});
      write_b(32'd1);
      cyc(3);
      write_b(32'd2);
      cyc(3);
      cpu_read(10, 32'd2);
`endif

      // CPU read collides with a JTAG read: JTAG first, then C_RD
      cpu_write(7, 32'h0777_0007);
      q_cpu.push_back(32'h0777_0007);
      q_j.push_back({1'b0, 32'hDEAD_BEEF});
      avs_address = AW'(7);
      avs_read = 1'b1;
      load_a(9'd5, 1'b1);
      n = 0;
      repeat (20) begin
         @(negedge clk);
         if (!avs_waitrequest) break;
         n++;
      end
      chk("collide_waits", n, 3);
      chk("collide_jtag_first", {31'd0, monitor_ready}, 32'd1);
      cyc(1);
      avs_read = 1'b0;
      cyc(2);

      // back-to-back strobes: second dropped, first completes
      q_j.push_back({1'b1, 32'hDEAD_BEEF});
      load_a(9'd5, 1'b1);
      read_na();
      cyc(4);
      chk("dup_error", {31'd0, monitor_error}, 32'd1);

      // reset during J_RD
      load_a(9'd5, 1'b1);
      reset_n = 1'b0;
      #1;
      chk("midrst_mondreg", MonDReg, 32'd0);
      chk("midrst_ready", {31'd0, monitor_ready}, 32'd0);
      chk("midrst_error", {31'd0, monitor_error}, 32'd0);
      chk("midrst_readdata", avs_readdata, 32'd0);
      chk("midrst_waitreq", {31'd0, avs_waitrequest}, 32'd0);
      cyc(1);
      reset_n = 1'b1;
      cyc(1);
      q_j.push_back({1'b0, 32'hDEAD_BEEF});
      load_a(9'd5, 1'b1);
      cyc(4);
      cpu_read(5, 32'hDEAD_BEEF);

      cyc(4);
      chk("jtag_queue_drained", q_j.size(), 32'd0);
      chk("cpu_queue_drained", q_cpu.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
